// File: rtl/sensors_intf_spi_slave_if.sv
// sensors_intf_spi_slave_if: SPI pins and CPU register port of the SPI slave
// master modport: SPI host + CPU side (drives SCLK/SS_n/MOSI and register strobes)
// slave modport:  the SPI slave block (drives MISO/MISO_oe, read data, irq, flags)
interface sensors_intf_spi_slave_if;
  logic        SCLK;
  logic        SS_n;
  logic        MOSI;
  logic        MISO;
  logic        MISO_oe;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;
  logic        dataavailable;
  logic        readyfordata;
  modport master (
    output SCLK, SS_n, MOSI, spi_select, mem_addr, read_n, write_n, data_from_cpu,
    input  MISO, MISO_oe, data_to_cpu, irq, dataavailable, readyfordata
  );
  modport slave (
    input  SCLK, SS_n, MOSI, spi_select, mem_addr, read_n, write_n, data_from_cpu,
    output MISO, MISO_oe, data_to_cpu, irq, dataavailable, readyfordata
  );
endinterface

// File: rtl/sensors_intf_spi_slave.sv
// sensors_intf_spi_slave: SPI mode-3 16-bit slave with CPU register port
// clk, reset : system clock, synchronous active-high reset
// bus        : slave modport carrying SCLK/SS_n/MOSI/MISO/MISO_oe and the
//              register port (spi_select, mem_addr, read_n, write_n,
//              data_from_cpu, data_to_cpu, irq, dataavailable, readyfordata)
module sensors_intf_spi_slave #(
  parameter int DATABITS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  sensors_intf_spi_slave_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WAITHI} state_t;
  state_t r_state;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic r_sclk_prev;
  logic [DATABITS-1:0] r_tx_shift, r_tx_hold, r_rx_hold, r_ctrl, r_dout;
  logic [DATABITS-2:0] r_rx_shift;
  logic [3:0] r_bitcnt;
  logic r_rrdy, r_trdy, r_roe, r_toe, r_tue, r_abt, r_irq;
  logic w_sclk, w_ss, w_mosi, w_ssa, w_rise, w_fall, w_err;
  logic w_wr, w_rd, w_tx_wr, w_st_wr, w_ct_wr, w_rx_rd;
  logic [15:0] w_status;
  // Synchronizers keep sampling through reset so that WAITHI sees the true
  // SS_n level as soon as reset is released.
  always_ff @(posedge clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
    r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus.SS_n};
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
    r_sclk_prev <= w_sclk;
  end
  assign w_sclk  = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss    = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi  = r_mosi_sync[SYNC_STAGES-1];
  // Selection is not acknowledged until the post-reset WAITHI state has
  // seen SS_n high, so a frame caught mid-way is ignored entirely.
  assign w_ssa   = ~w_ss & (r_state != WAITHI);
  assign w_rise  = w_ssa & ~r_sclk_prev & w_sclk;
  assign w_fall  = w_ssa & r_sclk_prev & ~w_sclk;
  assign w_wr    = bus.spi_select & ~bus.write_n;
  assign w_rd    = bus.spi_select & ~bus.read_n;
  assign w_tx_wr = w_wr & (bus.mem_addr == 3'd1);
  assign w_st_wr = w_wr & (bus.mem_addr == 3'd2);
  assign w_ct_wr = w_wr & (bus.mem_addr == 3'd3);
  assign w_rx_rd = w_rd & (bus.mem_addr == 3'd0);
  assign w_err   = r_roe | r_toe | r_tue | r_abt;
  assign w_status = {5'b0, r_abt, w_ssa, w_err, r_rrdy, r_trdy, r_tue, r_toe, r_roe, 3'b0};
  assign bus.MISO          = w_ssa ? r_tx_shift[DATABITS-1] : 1'b1;
  assign bus.MISO_oe       = w_ssa;
  assign bus.data_to_cpu   = r_dout;
  assign bus.irq           = r_irq;
  assign bus.dataavailable = r_rrdy;
  assign bus.readyfordata  = r_trdy;
  // Clears are issued before the SPI-side sets below so that a set event
  // in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= WAITHI;
      r_tx_shift <= '0;
      r_tx_hold  <= '0;
      r_rx_hold  <= '0;
      r_rx_shift <= '0;
      r_ctrl     <= '0;
      r_dout     <= '0;
      r_bitcnt   <= '0;
      r_rrdy     <= 1'b0;
      r_trdy     <= 1'b1;
      r_roe      <= 1'b0;
      r_toe      <= 1'b0;
      r_tue      <= 1'b0;
      r_abt      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= |(w_status[8:3] & r_ctrl[8:3]);
      if (w_rx_rd) r_rrdy <= 1'b0;
      if (w_st_wr) {r_roe, r_toe, r_tue, r_abt} <= 4'b0;
      if (w_ct_wr) r_ctrl <= bus.data_from_cpu & 16'h01F8;
      if (w_rd)
        r_dout <= bus.mem_addr == 3'd0 ? r_rx_hold :
                  bus.mem_addr == 3'd2 ? w_status :
                  bus.mem_addr == 3'd3 ? r_ctrl : '0;
      // The write decision uses TRDY from before any same-cycle LOAD.
      if (w_tx_wr) begin
        if (r_trdy) begin
          r_tx_hold <= bus.data_from_cpu;
          r_trdy    <= 1'b0;
        end else
          r_toe <= 1'b1;
      end
      case (r_state)
        WAITHI: if (w_ss) r_state <= IDLE;
        IDLE:   if (!w_ss) r_state <= LOAD;
        LOAD: begin
          if (w_ss)
            r_state <= IDLE;
          else if (w_fall) begin
            // First falling edge of a word: latch the queued word, or send
            // zeros and flag an underrun. No shift happens on this edge.
            if (!r_trdy) begin
              r_tx_shift <= r_tx_hold;
              r_trdy     <= 1'b1;
            end else begin
              r_tx_shift <= '0;
              r_tue      <= 1'b1;
            end
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_ss) begin
            if (r_bitcnt != 4'd0) r_abt <= 1'b1;
            r_bitcnt <= '0;
            r_state  <= IDLE;
          end else begin
            if (w_fall && r_bitcnt != 4'd0) r_tx_shift <= r_tx_shift << 1;
            if (w_rise) begin
              r_rx_shift <= {r_rx_shift[DATABITS-3:0], w_mosi};
              if (r_bitcnt == 4'(DATABITS - 1)) begin
                r_rx_hold <= {r_rx_shift, w_mosi};
                r_rrdy    <= 1'b1;
                if (r_rrdy && !w_rx_rd) r_roe <= 1'b1;
                r_bitcnt  <= '0;
                r_state   <= LOAD;
              end else
                r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
        end
        default: r_state <= WAITHI;
      endcase
    end
  end
endmodule

// File: tb/tb_sensors_intf_spi_slave.sv
// tb_sensors_intf_spi_slave: directed table-driven bench for the SPI slave
module tb_sensors_intf_spi_slave;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_pass = 0;
  int n_tot = 0;
  logic [15:0] d, mi;
  sensors_intf_spi_slave_if bus();
  sensors_intf_spi_slave dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #10 clk = ~clk;
  typedef struct {
    logic        wr_tx;
    logic [15:0] tx;
    logic [15:0] mosi;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
    logic [15:0] exp_status;
  } vec_t;
  vec_t vecs[4];
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask
  task automatic cpu_write(input logic [2:0] a, input logic [15:0] v);
    bus.spi_select = 1'b1;
    bus.write_n = 1'b0;
    bus.mem_addr = a;
    bus.data_from_cpu = v;
    tick(1);
    bus.spi_select = 1'b0;
    bus.write_n = 1'b1;
  endtask
  task automatic cpu_read(input logic [2:0] a, output logic [15:0] v);
    bus.spi_select = 1'b1;
    bus.read_n = 1'b0;
    bus.mem_addr = a;
    tick(1);
    bus.spi_select = 1'b0;
    bus.read_n = 1'b1;
    v = bus.data_to_cpu;
  endtask
  // Mode 3 master: drive MOSI on the falling edge, sample MISO just before the rise.
  task automatic shift(input logic [15:0] mo, input int n, output logic [15:0] rx);
    rx = '0;
    for (int i = 15; i > 15 - n; i--) begin
      bus.SCLK = 1'b0;
      bus.MOSI = mo[i];
      tick(5);
      rx[i] = bus.MISO;
      bus.SCLK = 1'b1;
      tick(5);
    end
  endtask
  task automatic frame(input logic [15:0] mo, input int n, output logic [15:0] rx);
    bus.SS_n = 1'b0;
    tick(6);
    shift(mo, n, rx);
    bus.SS_n = 1'b1;
    tick(6);
  endtask
  initial begin
    bus.SCLK = 1'b1;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    bus.spi_select = 1'b0;
    bus.read_n = 1'b1;
    bus.write_n = 1'b1;
    bus.mem_addr = 3'd0;
    bus.data_from_cpu = 16'h0;
    vecs[0] = '{1'b1, 16'hA5C3, 16'h1234, 16'hA5C3, 16'h1234, 16'h00C0};
    vecs[1] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h01E0};
    vecs[2] = '{1'b1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 16'h00C0};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h00C0};
    tick(5);
    chk("rst_miso", 16'(bus.MISO), 16'h1);
    chk("rst_miso_oe", 16'(bus.MISO_oe), 16'h0);
    chk("rst_dout", bus.data_to_cpu, 16'h0);
    chk("rst_irq", 16'(bus.irq), 16'h0);
    chk("rst_rrdy", 16'(bus.dataavailable), 16'h0);
    chk("rst_trdy", 16'(bus.readyfordata), 16'h1);
    reset = 1'b0;
    tick(3);
    cpu_read(3'd2, d);
    chk("rst_status", d, 16'h0040);
    cpu_read(3'd3, d);
    chk("rst_ctrl", d, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      cpu_write(3'd2, 16'h0);
      if (vecs[i].wr_tx) cpu_write(3'd1, vecs[i].tx);
      frame(vecs[i].mosi, 16, mi);
      chk($sformatf("v%0d_miso", i), mi, vecs[i].exp_miso);
      cpu_read(3'd2, d);
      chk($sformatf("v%0d_status", i), d, vecs[i].exp_status);
      cpu_read(3'd0, d);
      chk($sformatf("v%0d_rx", i), d, vecs[i].exp_rx);
    end
    // overrun: two words without a CPU read, ROE interrupt enabled
    cpu_write(3'd3, 16'hFFFF);
    cpu_read(3'd3, d);
    chk("ctrl_mask", d, 16'h01F8);
    cpu_write(3'd3, 16'h0008);
    cpu_write(3'd2, 16'h0);
    tick(2);
    chk("roe_irq_pre", 16'(bus.irq), 16'h0);
    bus.SS_n = 1'b0;
    tick(6);
    shift(16'h1111, 16, mi);
    shift(16'h5678, 16, mi);
    bus.SS_n = 1'b1;
    tick(6);
    chk("roe_irq", 16'(bus.irq), 16'h1);
    cpu_read(3'd2, d);
    chk("roe_status", d, 16'h01E8);
    cpu_read(3'd0, d);
    chk("roe_rx", d, 16'h5678);
    cpu_write(3'd2, 16'h0);
    chk("roe_irq_hold", 16'(bus.irq), 16'h1);
    tick(1);
    chk("roe_irq_drop", 16'(bus.irq), 16'h0);
    cpu_read(3'd2, d);
    chk("roe_cleared", d, 16'h0040);
    cpu_write(3'd3, 16'h0);
    // abort after 9 bits, then a clean frame
    frame(16'hABCD, 9, mi);
    chk("abt_rrdy", 16'(bus.dataavailable), 16'h0);
    cpu_read(3'd2, d);
    chk("abt_status", d, 16'h0560);
    cpu_write(3'd2, 16'h0);
    frame(16'h0F0F, 16, mi);
    cpu_read(3'd0, d);
    chk("abt_next_rx", d, 16'h0F0F);
    // tx overrun: second write dropped, first word transmitted
    cpu_write(3'd2, 16'h0);
    cpu_write(3'd1, 16'hAAAA);
    cpu_write(3'd1, 16'h5555);
    cpu_read(3'd2, d);
    chk("toe_status", d, 16'h0110);
    frame(16'h0000, 16, mi);
    chk("toe_miso", mi, 16'hAAAA);
    cpu_read(3'd2, d);
    chk("toe_status_after", d, 16'h01D0);
    cpu_read(3'd0, d);
    // reset in the middle of a frame with SS_n held low
    bus.SS_n = 1'b0;
    tick(6);
    shift(16'hFFFF, 5, mi);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    shift(16'hFFFF, 11, mi);
    tick(4);
    chk("mid_rrdy", 16'(bus.dataavailable), 16'h0);
    chk("mid_miso_oe", 16'(bus.MISO_oe), 16'h0);
    cpu_read(3'd2, d);
    chk("mid_status", d, 16'h0040);
    bus.SS_n = 1'b1;
    tick(6);
    frame(16'hBEEF, 16, mi);
    chk("mid_next_rrdy", 16'(bus.dataavailable), 16'h1);
    cpu_read(3'd0, d);
    chk("mid_next_rx", d, 16'hBEEF);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/sensors_intf_spi_slave.md
# sensors_intf_spi_slave

SPI slave (target) port with a CPU register interface: the far-end counterpart to the team's SPI master. It uses SPI mode 3 (CPOL=1, CPHA=1), 16-bit words, MSB first. SCLK, SS_n and MOSI are oversampled in the system clock domain, and MISO is returned from a double-buffered transmit path. It lets the FPGA act as the sensor/ADC endpoint for bench loopback, or serve an external SPI host.

## Interface
- DATABITS, 16, word width (fixed at 16 for this block)
- SYNC_STAGES, 2, synchronizer flops on SCLK/SS_n/MOSI
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- SCLK  in  1  SPI clock from master; idles high
- SS_n  in  1  slave select, active low
- MOSI  in  1  master-out data
- MISO  out  1  slave-out data; 1 when deselected
- MISO_oe  out  1  high while SS_n (synchronized) is low
- spi_select  in  1  register-port chip select
- mem_addr  in  3  0 rxdata (r), 1 txdata (w), 2 status (r; write clears), 3 control (r/w)
- read_n, write_n  in  1  active-low strobes
- data_from_cpu  in  16  write data
- data_to_cpu  out  16  registered read data
- irq  out  1  registered interrupt
- dataavailable  out  1  = RRDY
- readyfordata  out  1  = TRDY

## Operation
- Status bits: [3] ROE, [4] TOE, [5] TUE (tx underrun), [6] TRDY, [7] RRDY, [8] E = ROE|TOE|TUE|ABT, [9] SSA (selected), [10] ABT (aborted frame). All other bits read 0.
- Control bits: enables at [3..8] matching status positions. irq is registered: OR of each flag ANDed with its enable.
- Edge detect runs on the synchronized SCLK: rise = prev 1 / now 0 inverted, i.e. prev 0 and now 1; fall = prev 1 and now 0. Edges are ignored while SSA = 0.
- States:
  - IDLE: SS_n high.
  - LOAD: SS_n low, before the first falling edge.
  - SHIFT: bit counter 0..15.
  - WAITHI: after reset, until SS_n is seen high.
- IDLE→LOAD on synchronized SS_n fall. In LOAD, tx_shift ← tx_holding if TRDY = 0, and the holding register is freed (TRDY = 1). Otherwise tx_shift ← 16'h0000 and TUE is set.
- Rising edge: rx_shift ← {rx_shift[14:0], MOSI_sync}, bitcnt + 1.
- Falling edge with bitcnt ≠ 0: tx_shift ← tx_shift << 1. MISO = tx_shift[15].
- 16th rising edge: rx_holding ← the assembled word and RRDY ← 1. ROE ← 1 if RRDY was already 1 and was not cleared in the same cycle. bitcnt ← 0 and the state returns to LOAD, so the next word is loaded before the next falling edge.
- SS_n rises with bitcnt ∉ {0}: the partial word is discarded, ABT ← 1, and the state goes to IDLE. A tx word already loaded is lost.
- SS_n rises with bitcnt = 0: go to IDLE cleanly.
- Register write to addr 1:
  - If TRDY: tx_holding ← data and TRDY ← 0.
  - Else: the data is dropped and TOE ← 1. This applies even if a LOAD consumes the holding register in the same cycle.
- Read of addr 0 clears RRDY. Any write to addr 2 clears ROE, TOE, TUE and ABT; if a set event occurs in the same cycle, set wins.
- Reset exit goes to WAITHI, so a frame already in progress is never half-received.

## Timing
- Reset values:
  - MISO = 1, MISO_oe = 0, data_to_cpu = 0, irq = 0.
  - RRDY = 0, TRDY = 1, all error flags 0, control = 0.
  - tx/rx shift and holding registers = 0.
- Input-to-action latency is SYNC_STAGES + 1 clk after a pin transition.
- MISO updates 3 clk after the physical SCLK fall.
- Requirement: SCLK high and low times each ≥ 4 clk, and SS_n setup ≥ 4 clk before the first SCLK fall.
- Reads: data_to_cpu is valid on the clk after spi_select & ~read_n and holds until the next read.
- Writes: take effect on the clk where spi_select & ~write_n is sampled. The register port assumes single-cycle strobes.
- RRDY/dataavailable asserts 1 clk after the 16th synchronized rising edge. irq follows 1 clk later.

## Test plan
- CPU writes 16'hA5C3 to txdata; the master clocks 16'h1234 in mode 3 → master receives A5C3, rxdata reads 16'h1234, RRDY = 1, TRDY = 1, no errors.
- Two back-to-back words with no CPU read → second word 16'h5678 is in rxdata, ROE = 1; with ROE enabled, irq = 1. A status write clears ROE and irq drops 1 clk later.
- No tx word queued, frame 16'hFFFF → MISO shifts 16'h0000, TUE = 1, rxdata = 16'hFFFF.
- SS_n deasserted after 9 bits → ABT = 1, RRDY unchanged. The next full frame 16'h0F0F is received correctly.
- Reset asserted mid-frame with SS_n low, then released → no RRDY and no shifting until SS_n goes high; the subsequent frame 16'hBEEF is received correctly.
- Two txdata writes with no transfer in between → the second write is dropped, TOE = 1, and the first value is transmitted.
